// File: rtl/ysyx_23060208_pkg.sv
// Shared definitions for the ysyx_23060208 fetch unit: FSM encoding, reset PC,
// bus response codes and the trap instruction substituted on a fetch error.
package ysyx_23060208_pkg;

  typedef enum logic [2:0] {
    IFU_IDLE,
    IFU_WAITPC,
    IFU_AR,
    IFU_R,
    IFU_HOLD
  } ifu_state_e;

  localparam logic [31:0] RESET_PC = 32'h7FFF_FFFC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

endpackage

// File: rtl/ysyx_23060208_ifu.sv
// Instruction fetch unit: one outstanding AXI-lite style read per PC, handed to
// decode through a valid/ready hold stage. Optional: YSYX_23060208_IFU_RESP_ERR_EN.
module ysyx_23060208_ifu
  import ysyx_23060208_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic                  pc_wen,
  input  logic                  pc_update,
  output logic [DATA_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [DATA_WIDTH-1:0] inst_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic                  fetch_err
);

  ifu_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic [DATA_WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic                  r_beat;

  assign r_beat = (state_q == IFU_R) && rvalid;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IFU_IDLE;
      araddr_q  <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IFU_IDLE:   state_d = IFU_WAITPC;
      IFU_WAITPC: if (pc_update)  state_d = IFU_AR;
      IFU_AR:     if (arready)    state_d = IFU_R;
      IFU_R:      if (rvalid)     state_d = IFU_HOLD;
      IFU_HOLD:   if (inst_ready) state_d = IFU_WAITPC;
      default:    state_d = IFU_IDLE;
    endcase
  end

  // Address and PC are captured together so decode sees the PC that was fetched.
  always_comb begin
    araddr_d  = araddr_q;
    inst_pc_d = inst_pc_q;
    inst_d    = inst_q;
    if (state_q == IFU_WAITPC && pc_update) begin
      araddr_d  = pc;
      inst_pc_d = pc;
    end
    if (r_beat) begin
      inst_d = rdata;
`ifdef YSYX_23060208_IFU_RESP_ERR_EN
      if (rresp != RESP_OKAY) inst_d = DATA_WIDTH'(EBREAK);
`endif
    end
  end

`ifdef YSYX_23060208_IFU_RESP_ERR_EN
  logic fetch_err_q, fetch_err_d;

  always_comb begin
    fetch_err_d = fetch_err_q;
    if (r_beat && rresp != RESP_OKAY) fetch_err_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) fetch_err_q <= 1'b0;
    else       fetch_err_q <= fetch_err_d;
  end

  assign fetch_err = fetch_err_q;
`else
  logic unused_rresp;
  assign unused_rresp = ^rresp;
  assign fetch_err    = 1'b0;
`endif

  // Outputs are gated by reset so nothing leaks out while reset is held in IDLE.
  always_comb begin
    arvalid    = 1'b0;
    rready     = 1'b0;
    inst_valid = 1'b0;
    pc_wen     = 1'b0;
    if (!reset) begin
      arvalid    = (state_q == IFU_AR);
      rready     = (state_q == IFU_R);
      inst_valid = (state_q == IFU_HOLD);
      pc_wen     = (state_q == IFU_IDLE) || ((state_q == IFU_HOLD) && inst_ready);
    end
  end

  assign araddr  = araddr_q;
  assign inst    = inst_q;
  assign inst_pc = inst_pc_q;

endmodule

// File: tb/tb_ysyx_23060208_ifu.sv
// Directed self-checking bench for ysyx_23060208_ifu; expected values are hand-derived.
module tb_ysyx_23060208_ifu;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        pc_wen;
  logic        pc_update;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        fetch_err;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  ysyx_23060208_ifu #(.DATA_WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .pc         (pc),
    .pc_wen     (pc_wen),
    .pc_update  (pc_update),
    .araddr     (araddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .fetch_err  (fetch_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic upd, input logic [31:0] p, input logic ar_rdy,
                               input logic r_vld, input logic [31:0] data,
                               input logic [1:0] resp, input logic i_rdy);
    pc_update  = upd;
    pc         = p;
    arready    = ar_rdy;
    rvalid     = r_vld;
    rdata      = data;
    rresp      = resp;
    inst_ready = i_rdy;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 32'h7FFF_FFFC, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
    repeat (2) step();

    checkOutput("rst_pc_wen",     {31'b0, pc_wen},     32'd0);
    checkOutput("rst_arvalid",    {31'b0, arvalid},    32'd0);
    checkOutput("rst_rready",     {31'b0, rready},     32'd0);
    checkOutput("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("rst_fetch_err",  {31'b0, fetch_err},  32'd0);
    checkOutput("rst_inst",       inst,                32'd0);
    checkOutput("rst_inst_pc",    inst_pc,             32'd0);
    checkOutput("rst_araddr",     araddr,              32'd0);

    reset = 1'b0;
    #1;
    checkOutput("idle_pc_wen", {31'b0, pc_wen}, 32'd1);
    step();
    checkOutput("waitpc_pc_wen",     {31'b0, pc_wen},     32'd0);
    checkOutput("waitpc_arvalid",    {31'b0, arvalid},    32'd0);
    checkOutput("waitpc_inst_valid", {31'b0, inst_valid}, 32'd0);
    step();
    checkOutput("waitpc_stay_arvalid", {31'b0, arvalid}, 32'd0);

    // Fastest fetch: arready and rvalid high from the start
    applyStimulus(1'b1, 32'h8000_0000, 1'b1, 1'b1, 32'h0000_0413, 2'b00, 1'b0);
    step();
    checkOutput("fast_ar_arvalid", {31'b0, arvalid}, 32'd1);
    checkOutput("fast_ar_araddr",  araddr,           32'h8000_0000);
    checkOutput("fast_ar_rready",  {31'b0, rready},  32'd0);
    pc_update = 1'b0;
    step();
    checkOutput("fast_r_rready",     {31'b0, rready},     32'd1);
    checkOutput("fast_r_inst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("fast_r_arvalid",    {31'b0, arvalid},    32'd0);
    step();
    checkOutput("fast_hold_valid",   {31'b0, inst_valid}, 32'd1);
    checkOutput("fast_hold_inst",    inst,                32'h0000_0413);
    checkOutput("fast_hold_inst_pc", inst_pc,             32'h8000_0000);
    checkOutput("fast_hold_nowen",   {31'b0, pc_wen},     32'd0);
    inst_ready = 1'b1;
    #1;
    checkOutput("fast_hold_pc_wen", {31'b0, pc_wen}, 32'd1);
    step();
    checkOutput("fast_back_valid",  {31'b0, inst_valid}, 32'd0);
    checkOutput("fast_back_pc_wen", {31'b0, pc_wen},     32'd0);

    // Slow slave and slow decode
    applyStimulus(1'b1, 32'h8000_0004, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
    step();
    pc_update = 1'b0;
    pc        = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("stall_ar_arvalid_%0d", i), {31'b0, arvalid}, 32'd1);
      checkOutput($sformatf("stall_ar_araddr_%0d", i),  araddr,           32'h8000_0004);
      step();
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    checkOutput("stall_r_rready", {31'b0, rready}, 32'd1);
    step();
    checkOutput("stall_r_wait_rready", {31'b0, rready},     32'd1);
    checkOutput("stall_r_wait_valid",  {31'b0, inst_valid}, 32'd0);
    rvalid = 1'b1;
    rdata  = 32'h00A0_0093;
    step();
    rvalid = 1'b0;
    rdata  = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      pc_update = (i == 1);
      checkOutput($sformatf("stall_hold_valid_%0d", i), {31'b0, inst_valid}, 32'd1);
      checkOutput($sformatf("stall_hold_inst_%0d", i),  inst,                32'h00A0_0093);
      checkOutput($sformatf("stall_hold_pc_%0d", i),    inst_pc,             32'h8000_0004);
      checkOutput($sformatf("stall_hold_wen_%0d", i),   {31'b0, pc_wen},     32'd0);
      step();
    end
    pc_update  = 1'b0;
    inst_ready = 1'b1;
    #1;
    checkOutput("stall_hold_pc_wen", {31'b0, pc_wen}, 32'd1);
    step();
    inst_ready = 1'b0;
    checkOutput("noqueue_arvalid_0", {31'b0, arvalid}, 32'd0);
    step();
    checkOutput("noqueue_arvalid_1", {31'b0, arvalid}, 32'd0);

    // Reset in the middle of the read phase
    applyStimulus(1'b1, 32'h8000_0008, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0);
    step();
    pc_update = 1'b0;
    step();
    checkOutput("midrst_in_r", {31'b0, rready}, 32'd1);
    reset = 1'b1;
    step();
    checkOutput("midrst_rready",  {31'b0, rready}, 32'd0);
    checkOutput("midrst_araddr",  araddr,          32'd0);
    checkOutput("midrst_inst_pc", inst_pc,         32'd0);
    reset  = 1'b0;
    rvalid = 1'b1;
    rdata  = 32'hCAFE_F00D;
    #1;
    checkOutput("midrst_idle_wen", {31'b0, pc_wen}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput($sformatf("late_rvalid_valid_%0d", i), {31'b0, inst_valid}, 32'd0);
      checkOutput($sformatf("late_rvalid_inst_%0d", i),  inst,                32'd0);
    end
    rvalid = 1'b0;

    // Error response handling
    applyStimulus(1'b1, 32'h8000_000C, 1'b1, 1'b1, 32'h0000_0413, 2'b10, 1'b0);
    repeat (3) begin
      step();
      pc_update = 1'b0;
    end
    checkOutput("err_hold_valid", {31'b0, inst_valid}, 32'd1);
`ifdef YSYX_23060208_IFU_RESP_ERR_EN
    checkOutput("err_inst",      inst,                32'h0010_0073);
    checkOutput("err_fetch_err", {31'b0, fetch_err},  32'd1);
`else
    checkOutput("err_inst",      inst,                32'h0000_0413);
    checkOutput("err_fetch_err", {31'b0, fetch_err},  32'd0);
`endif
    inst_ready = 1'b1;
    step();
    applyStimulus(1'b1, 32'h8000_0010, 1'b1, 1'b1, 32'h0000_0013, 2'b00, 1'b0);
    repeat (3) begin
      step();
      pc_update = 1'b0;
    end
    checkOutput("ok_after_err_inst",    inst,    32'h0000_0013);
    checkOutput("ok_after_err_inst_pc", inst_pc, 32'h8000_0010);
`ifdef YSYX_23060208_IFU_RESP_ERR_EN
    checkOutput("ok_after_err_sticky", {31'b0, fetch_err}, 32'd1);
`else
    checkOutput("ok_after_err_sticky", {31'b0, fetch_err}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
